// File: rtl/func_arb_ctrl.sv
// Two-channel round-robin controller in front of a shared, registered add block.
// Define FUNC_ARB_CTRL_OPCNT_EN to add the 16-bit oOpCnt completed-operation counter.
module func_arb_ctrl #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReq0,
  input  logic        iReq1,
  input  logic [31:0] iA0,
  input  logic [31:0] iB0,
  input  logic [31:0] iA1,
  input  logic [31:0] iB1,
  output logic        oGnt0,
  output logic        oGnt1,
  output logic        oDone0,
  output logic        oDone1,
  output logic [31:0] oResult,
  output logic        oBusy,
  output logic [31:0] oInA,
  output logic [31:0] oInB,
  input  logic [31:0] iOutC
`ifdef FUNC_ARB_CTRL_OPCNT_EN
  ,
  output logic [15:0] oOpCnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  localparam logic [3:0] LatLoad = 4'(LATENCY);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q;
  logic        lastGnt_q;
  logic [31:0] opA_q, opB_q, result_q;
  logic        isIdle, pick1, gnt0, gnt1;

  // Channel 1 wins when it requests alone, or on a tie when channel 0 was granted last.
  always_comb begin
    isIdle = (state_q == IDLE);
    pick1  = iReq1 & (~iReq0 | ~lastGnt_q);
    gnt0   = iReq0 & ~pick1 & isIdle & ~iRst;
    gnt1   = iReq1 &  pick1 & isIdle & ~iRst;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt0 | gnt1) begin
          state_d = EXEC;
          cnt_d   = LatLoad;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = CAPT;
      end
      CAPT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      owner_q   <= 1'b0;
      lastGnt_q <= 1'b1;
      opA_q     <= 32'd0;
      opB_q     <= 32'd0;
      result_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (gnt0 | gnt1) begin
        opA_q     <= gnt1 ? iA1 : iA0;
        opB_q     <= gnt1 ? iB1 : iB0;
        owner_q   <= gnt1;
        lastGnt_q <= gnt1;
      end
      if (state_q == CAPT) result_q <= iOutC;
    end
  end

`ifdef FUNC_ARB_CTRL_OPCNT_EN
  logic [15:0] opCnt_q;

  always_ff @(posedge iClk) begin
    if (iRst) opCnt_q <= 16'd0;
    else if (state_q == RESP) opCnt_q <= opCnt_q + 16'd1;
  end

  assign oOpCnt = opCnt_q;
`endif

  // Reset overrides every output immediately, not only from the next edge.
  assign oGnt0   = gnt0;
  assign oGnt1   = gnt1;
  assign oDone0  = (state_q == RESP) & ~owner_q & ~iRst;
  assign oDone1  = (state_q == RESP) &  owner_q & ~iRst;
  assign oBusy   = ~isIdle & ~iRst;
  assign oResult = iRst ? 32'd0 : result_q;
  assign oInA    = iRst ? 32'd0 : opA_q;
  assign oInB    = iRst ? 32'd0 : opB_q;

endmodule

// File: tb/tb_func_arb_ctrl.sv
// Directed bench for func_arb_ctrl: one LATENCY=1 instance and one LATENCY=4 instance,
// each fed by a bench model of the registered add block.
module tb_func_arb_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [31:0] result, inA, inB, outC;

  logic        req0L4;
  logic [31:0] a0L4, b0L4;
  logic        gnt0L4, gnt1L4, done0L4, done1L4, busyL4;
  logic [31:0] resultL4, inAL4, inBL4, outCL4;
  logic [31:0] pipeL4 [4];

`ifdef FUNC_ARB_CTRL_OPCNT_EN
  logic [15:0] opCnt, opCntL4;
`endif

  int checkCount = 0;
  int errorCount = 0;

  always #5 clock = ~clock;

  func_arb_ctrl #(.LATENCY(1)) dut (
    .iClk(clock), .iRst(reset), .iReq0(req0), .iReq1(req1),
    .iA0(a0), .iB0(b0), .iA1(a1), .iB1(b1),
    .oGnt0(gnt0), .oGnt1(gnt1), .oDone0(done0), .oDone1(done1),
    .oResult(result), .oBusy(busy), .oInA(inA), .oInB(inB), .iOutC(outC)
`ifdef FUNC_ARB_CTRL_OPCNT_EN
    , .oOpCnt(opCnt)
`endif
  );

  func_arb_ctrl #(.LATENCY(4)) dutL4 (
    .iClk(clock), .iRst(reset), .iReq0(req0L4), .iReq1(1'b0),
    .iA0(a0L4), .iB0(b0L4), .iA1(32'd0), .iB1(32'd0),
    .oGnt0(gnt0L4), .oGnt1(gnt1L4), .oDone0(done0L4), .oDone1(done1L4),
    .oResult(resultL4), .oBusy(busyL4), .oInA(inAL4), .oInB(inBL4), .iOutC(outCL4)
`ifdef FUNC_ARB_CTRL_OPCNT_EN
    , .oOpCnt(opCntL4)
`endif
  );

  // Add-block models: one register stage for the LATENCY=1 unit, four for the other.
  always @(posedge clock) outC <= inA + inB;

  always @(posedge clock) begin
    pipeL4[0] <= inAL4 + inBL4;
    for (int i = 1; i < 4; i++) pipeL4[i] <= pipeL4[i-1];
  end
  assign outCL4 = pipeL4[3];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic [31:0] ia0,
                               input logic [31:0] ib0, input logic [31:0] ia1, input logic [31:0] ib1);
    req0 = r0; req1 = r1;
    a0 = ia0; b0 = ib0; a1 = ia1; b1 = ib1;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0L4 = 1'b0; a0L4 = 32'd0; b0L4 = 32'd0;
    applyStimulus(1'b1, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0);
    nextCycle();
    checkOutput("rstGnt0", gnt0, 1'b0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstResult", result, 32'd0);
    checkOutput("rstInA", inA, 32'd0);
    checkOutput("rstDone0", done0, 1'b0);

    // Single op with channel-0 re-request during RESP, then a busy-time channel-1 wrap op.
    nextCycle(); reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0);
    checkOutput("c0Gnt0", gnt0, 1'b1);
    checkOutput("c0Gnt1", gnt1, 1'b0);
    checkOutput("c0Busy", busy, 1'b0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0);
    checkOutput("c1Busy", busy, 1'b1);
    checkOutput("c1InA", inA, 32'd5);
    checkOutput("c1InB", inB, 32'd7);
    nextCycle();
    checkOutput("c2Busy", busy, 1'b1);
    checkOutput("c2Done0", done0, 1'b0);
    nextCycle(); applyStimulus(1'b1, 1'b0, 32'h10, 32'h20, 32'd0, 32'd0);
    checkOutput("c3Done0", done0, 1'b1);
    checkOutput("c3Result", result, 32'h0000000C);
    checkOutput("c3Busy", busy, 1'b1);
    checkOutput("c3RespNoGnt", gnt0, 1'b0);
    checkOutput("c3InAHeld", inA, 32'd5);
    nextCycle();
    checkOutput("c4Gnt0", gnt0, 1'b1);
    checkOutput("c4Done0", done0, 1'b0);
    checkOutput("c4ResultHeld", result, 32'h0000000C);
    nextCycle(); applyStimulus(1'b0, 1'b1, 32'h10, 32'h20, 32'hFFFFFFFF, 32'd2);
    checkOutput("c5InA", inA, 32'h10);
    checkOutput("c5Gnt1", gnt1, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("c7Done0", done0, 1'b1);
    checkOutput("c7Result", result, 32'h30);
    checkOutput("c7Gnt1", gnt1, 1'b0);
    nextCycle();
    checkOutput("c8Gnt1", gnt1, 1'b1);
    checkOutput("c8Gnt0", gnt0, 1'b0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd2);
    checkOutput("c9InA", inA, 32'hFFFFFFFF);
    checkOutput("c9InB", inB, 32'd2);
    nextCycle();
    nextCycle();
    checkOutput("c11Done1", done1, 1'b1);
    checkOutput("c11Done0", done0, 1'b0);
    checkOutput("c11WrapResult", result, 32'h00000001);
    nextCycle();
    checkOutput("c12Busy", busy, 1'b0);
    checkOutput("c12Done1", done1, 1'b0);

    // Channel-0 op aborted by reset in its third cycle.
    nextCycle(); applyStimulus(1'b1, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0);
    checkOutput("abGnt0", gnt0, 1'b1);
    nextCycle(); applyStimulus(1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0);
    nextCycle(); reset = 1'b1; #1;
    checkOutput("abRstBusy", busy, 1'b0);
    checkOutput("abRstDone0", done0, 1'b0);
    nextCycle(); reset = 1'b0; #1;
    checkOutput("abBusy", busy, 1'b0);
    checkOutput("abResult", result, 32'd0);
    checkOutput("abDone0", done0, 1'b0);
    nextCycle();
    checkOutput("abDone0Late", done0, 1'b0);
    checkOutput("abResultLate", result, 32'd0);

    // Continuous tie: the reset pointer gives channel 0 first, then strict alternation.
    nextCycle(); applyStimulus(1'b1, 1'b1, 32'd1, 32'd1, 32'd2, 32'd2);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) nextCycle();
      if (k == 13) applyStimulus(1'b0, 1'b0, 32'd1, 32'd1, 32'd2, 32'd2);
      checkOutput($sformatf("tieGnt0_%0d", k), gnt0, (k % 4 == 0) && ((k / 4) % 2 == 0));
      checkOutput($sformatf("tieGnt1_%0d", k), gnt1, (k % 4 == 0) && ((k / 4) % 2 == 1));
      checkOutput($sformatf("tieDone0_%0d", k), done0, (k % 4 == 3) && ((k / 4) % 2 == 0));
      checkOutput($sformatf("tieDone1_%0d", k), done1, (k % 4 == 3) && ((k / 4) % 2 == 1));
      if (k % 4 == 3)
        checkOutput($sformatf("tieResult_%0d", k), result, ((k / 4) % 2 == 0) ? 32'd2 : 32'd4);
    end

    // LATENCY=4: three back-to-back channel-0 ops, grant every 7 cycles, done 6 after grant.
    nextCycle();
    req0L4 = 1'b1; a0L4 = 32'h100; b0L4 = 32'h23; #1;
    for (int k = 0; k < 21; k++) begin
      if (k > 0) nextCycle();
      if (k == 15) begin req0L4 = 1'b0; #1; end
      checkOutput($sformatf("l4Gnt0_%0d", k), gnt0L4, (k % 7 == 0) && (k < 15));
      checkOutput($sformatf("l4Done0_%0d", k), done0L4, (k % 7 == 6));
      if (k % 7 == 6) checkOutput($sformatf("l4Result_%0d", k), resultL4, 32'h123);
    end
    nextCycle();
    checkOutput("l4Idle", busyL4, 1'b0);
`ifdef FUNC_ARB_CTRL_OPCNT_EN
    checkOutput("l4OpCnt3", opCntL4, 16'd3);
    checkOutput("l1OpCnt", opCnt, 16'd4);
    force dutL4.opCnt_q = 16'hFFFF;
    #1;
    release dutL4.opCnt_q;
    nextCycle();
    req0L4 = 1'b1; #1;
    checkOutput("pwGnt0", gnt0L4, 1'b1);
    for (int k = 1; k < 8; k++) begin
      nextCycle();
      if (k == 1) begin req0L4 = 1'b0; #1; end
      if (k == 6) checkOutput("pwOpCntFFFF", opCntL4, 16'hFFFF);
      if (k == 7) checkOutput("pwOpCntWrap", opCntL4, 16'h0000);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
